// File: rtl/tick_gen.sv
// Prescaled enable generator: one-cycle strobe every div+1 clocks, free-run or burst.
// Optional `TICK_GEN_RESTART_EN`: start while running re-latches config and restarts timing.
module tick_gen #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] burst_len,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pulses
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mode_q, mode_d;
  logic [LEN_W:0]     rem_q, rem_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   pulses_q, pulses_d;
  logic               accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      div_q    <= '0;
      mode_q   <= 1'b0;
      rem_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pulses_q <= pulses_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    div_d    = div_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    pulses_d = pulses_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) accept = 1'b1;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
`ifdef TICK_GEN_RESTART_EN
        end else if (start) begin
          accept = 1'b1;
`endif
        // rem_q reaches 0 only on the edge that issued the final burst strobe
        end else if (mode_q && (rem_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pre_q == div_q) begin
          enable_d = 1'b1;
          pre_d    = '0;
          pulses_d = pulses_q + LEN_W'(1);
          if (mode_q) rem_d = rem_q - (LEN_W+1)'(1);
        end else begin
          pre_d = pre_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RUN;
      div_d    = div;
      mode_d   = mode;
      rem_d    = (burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len};
      pre_d    = '0;
      pulses_d = '0;
    end

    busy_d = (state_d == RUN);
  end

  always_comb begin
    enable = enable_q;
    busy   = busy_q;
    done   = done_q;
    pulses = pulses_q;
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen against an arithmetic timing model.
module tb_tick_gen;

  logic       clk = 1'b0;
  logic       reset, start, stop, mode;
  logic [7:0] div, burst_len;
  logic       enable, busy, done;
  logic [7:0] pulses;
  logic [10:0] obs;

  int errors = 0;
  int checks = 0;

  tick_gen #(.DIV_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .div(div), .burst_len(burst_len),
    .enable(enable), .busy(busy), .done(done), .pulses(pulses)
  );

  assign obs = {enable, busy, done, pulses};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {enable,busy,done,pulses} at edge E0+k, from the timing rules.
  task automatic model(input int d, input int m, input int n, input int k, output logic [10:0] v);
    int p, last, kk, pul;
    logic en, bz, dn;
    p = d + 1;
    if (m == 0) begin
      en = (k > 0) && (k % p == 0);
      bz = 1'b1;
      dn = 1'b0;
      pul = k / p;
    end else begin
      last = n * p;
      en = (k > 0) && (k % p == 0) && (k <= last);
      bz = (k <= last);
      dn = (k == last + 1);
      kk = (k < last) ? k : last;
      pul = kk / p;
    end
    v = {en, bz, dn, 8'(pul)};
  endtask

  // Called #1 after an edge; returns #1 after E0 with config inputs scrambled.
  task automatic go(input int d, input int m, input int l);
    start = 1'b1;
    div = 8'(d);
    mode = m[0];
    burst_len = 8'(l);
    tick();
    start = 1'b0;
    div = 8'($urandom);
    mode = 1'($urandom);
    burst_len = 8'($urandom);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; div = '0; burst_len = '0;
    #2;
    checks++;
    if (obs !== 11'd0) begin errors++; $display("FAIL reset_init got=%b exp=%b", obs, 11'd0); end
    #20 reset = 1'b0;
    tick();
    go(2, 1, 10);
    n = $urandom_range(3, 20);
    repeat (n) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 11'd0) begin errors++; $display("FAIL reset_async got=%b exp=%b", obs, 11'd0); end
    #2 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs !== 11'd0) begin errors++; $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs, 11'd0); end
    end
  endtask

  task automatic test_burst();
    logic [10:0] v;
    go(3, 1, 5);
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) tick();
      model(3, 1, 5, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL burst k=%0d got=%b exp=%b", k, obs, v); end
    end
  endtask

  task automatic test_freerun_wrap();
    logic [10:0] v;
    go(0, 0, 0);
    for (int k = 0; k <= 300; k++) begin
      if (k > 0) tick();
      model(0, 0, 0, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL freerun k=%0d got=%b exp=%b", k, obs, v); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (obs !== {3'b000, 8'd44}) begin errors++; $display("FAIL freerun_stop got=%b exp=%b", obs, {3'b000, 8'd44}); end
  endtask

  task automatic test_stop();
    logic [10:0] v;
    go(2, 0, 0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      model(2, 0, 0, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL stop_run k=%0d got=%b exp=%b", k, obs, v); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      checks++;
      if (obs !== {3'b000, 8'd2}) begin errors++; $display("FAIL stop_hold j=%0d got=%b exp=%b", j, obs, {3'b000, 8'd2}); end
    end
  endtask

  task automatic test_burst_zero();
    logic [10:0] v;
    go(0, 1, 0);
    for (int k = 0; k <= 259; k++) begin
      if (k > 0) tick();
      model(0, 1, 256, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL burst_zero k=%0d got=%b exp=%b", k, obs, v); end
    end
  endtask

  task automatic test_restart();
    logic [10:0] v;
    go(4, 0, 0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      model(4, 0, 0, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL restart_pre k=%0d got=%b exp=%b", k, obs, v); end
    end
    start = 1'b1; div = 8'd1; mode = 1'b0; burst_len = 8'd0;
    tick();
    start = 1'b0;
`ifdef TICK_GEN_RESTART_EN
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) tick();
      model(1, 0, 0, j, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL restart_new j=%0d got=%b exp=%b", j, obs, v); end
    end
`else
    for (int k = 8; k <= 21; k++) begin
      if (k > 8) tick();
      model(4, 0, 0, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL restart_ignored k=%0d got=%b exp=%b", k, obs, v); end
    end
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_stop busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] v;
    go(1, 1, 2);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      model(1, 1, 2, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL b2b_first k=%0d got=%b exp=%b", k, obs, v); end
    end
    go(0, 1, 3);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      model(0, 1, 3, k, v);
      checks++;
      if (obs !== v) begin errors++; $display("FAIL b2b_second k=%0d got=%b exp=%b", k, obs, v); end
    end
  endtask

  task automatic test_random();
    logic [10:0] v;
    int d, m, l, n, lim;
    repeat (8) begin
      d = $urandom_range(0, 5);
      m = $urandom_range(0, 1);
      l = $urandom_range(0, 7);
      n = (l == 0) ? 256 : l;
      lim = (m == 1) ? n * (d + 1) + 2 : $urandom_range(5, 40);
      go(d, m, l);
      for (int k = 0; k <= lim; k++) begin
        if (k > 0) tick();
        model(d, m, n, k, v);
        checks++;
        if (obs !== v) begin errors++; $display("FAIL random d=%0d m=%0d n=%0d k=%0d got=%b exp=%b", d, m, n, k, obs, v); end
      end
      if (m == 0) begin
        model(d, 0, n, lim, v);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (obs !== {3'b000, v[7:0]}) begin errors++; $display("FAIL random_stop d=%0d got=%b exp=%b", d, obs, {3'b000, v[7:0]}); end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_freerun_wrap();
    test_stop();
    test_burst_zero();
    test_restart();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
